// File: rtl/run4_pkg.sv
// Shared types for the run-of-four detector and the scheduler that multiplexes it.
package run4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } det_state_t;

    localparam int RUN_LEN = 4;

endpackage

// File: rtl/run4_detector.sv
// Serial run-of-four detector with a Mealy hit on every bit that brings an
// equal-bit run to RUN_LEN or beyond since the last clear.
module run4_detector
    import run4_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic in,
    input  logic en,
    output logic hit
);

    det_state_t state, state_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   state <= S0;
        else if (clr) state <= S0;
        else if (en)  state <= state_nx;
    end

    // S1..S4 count a run of 0s, S5..S8 a run of 1s; S4/S8 saturate at RUN_LEN.
    always_comb begin
        state_nx = S0;
        case (state)
            S0:      state_nx = in ? S5 : S1;
            S1:      state_nx = in ? S5 : S2;
            S2:      state_nx = in ? S5 : S3;
            S3, S4:  state_nx = in ? S5 : S4;
            S5:      state_nx = in ? S6 : S1;
            S6:      state_nx = in ? S7 : S1;
            S7, S8:  state_nx = in ? S8 : S1;
            default: state_nx = S0;
        endcase
    end

    assign hit = en & ~clr & ((state_nx == S4) | (state_nx == S8));

endmodule

// File: rtl/run4_detect_scheduler.sv
// Round-robin scheduler that streams one requester's word at a time MSB-first
// through the shared run-of-four detector and reports per-word and total hits.
module run4_detect_scheduler
    import run4_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W - 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic                      any_hit,
    output logic                      busy,
    output logic [15:0]               hits_total
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    sched_state_t      state, state_nx;
    logic [IDX_W-1:0]  rr_ptr, owner, pick_idx;
    logic              pick_vld;
    logic [DATA_W-1:0] words [N_REQ];
    logic [DATA_W-1:0] sh;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  word_hits, word_hits_nx;
    logic              det_en, det_clr, det_hit;

    // First requester at or after ptr, wrapping; MSB of the result flags a valid pick.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [CNT_W-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) words[i] = data[i*DATA_W +: DATA_W];
    end

    assign {pick_vld, pick_idx} = rr_pick(req, rr_ptr);
    assign word_hits_nx         = word_hits + CNT_W'(det_hit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_vld) state_nx = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        det_en  = (state == SHIFT);
        det_clr = (state == IDLE);
    end

    // Word payload carries no reset; it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && pick_vld) sh <= words[pick_idx];
        else if (state == SHIFT)       sh <= {sh[DATA_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt        <= '0;
            done       <= '0;
            hit_cnt    <= '0;
            any_hit    <= 1'b0;
            hits_total <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            bit_cnt    <= '0;
            word_hits  <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: if (pick_vld) begin
                    owner     <= pick_idx;
                    gnt       <= N_REQ'(1) << pick_idx;
                    bit_cnt   <= '0;
                    word_hits <= '0;
                end
                SHIFT: begin
                    word_hits <= word_hits_nx;
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        done    <= N_REQ'(1) << owner;
                        hit_cnt <= word_hits_nx;
                        any_hit <= (word_hits_nx != '0);
                    end
                end
                DONE: begin
                    hits_total <= sat_add16(hits_total, word_hits);
                    rr_ptr     <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    run4_detector u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (det_clr),
        .in    (sh[DATA_W-1]),
        .en    (det_en),
        .hit   (det_hit)
    );

endmodule

// File: tb/tb_run4_detect_scheduler.sv
// Bench for run4_detect_scheduler: directed scenarios plus randomized words
// checked against a run-length and round-robin reference model.
module tb_run4_detect_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt, done;
    logic [2:0]  hit_cnt;
    logic        any_hit, busy;
    logic [15:0] hits_total;

    logic        reset2;
    logic [1:0]  req2;
    logic [31:0] data2;
    logic [1:0]  gnt2, done2;
    logic [3:0]  hit_cnt2;
    logic        any_hit2, busy2;
    logic [15:0] hits_total2;

    int total = 0;
    int bad   = 0;
    int exp_total;
    int exp_ptr;

    always #5 clk = ~clk;

    run4_detect_scheduler #(.N_REQ(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt), .done(done),
        .hit_cnt(hit_cnt), .any_hit(any_hit), .busy(busy), .hits_total(hits_total)
    );

    run4_detect_scheduler #(.N_REQ(2), .DATA_W(16)) u_sat (
        .clk(clk), .reset(reset2), .req(req2), .data(data2), .gnt(gnt2), .done(done2),
        .hit_cnt(hit_cnt2), .any_hit(any_hit2), .busy(busy2), .hits_total(hits_total2)
    );

    function automatic int ref_hits(input logic [15:0] w, input int width);
        int   run, hits;
        logic prev, b;
        run = 0; hits = 0; prev = 1'b0;
        for (int k = width - 1; k >= 0; k--) begin
            b    = w[k];
            run  = (k == width - 1 || b != prev) ? 1 : run + 1;
            if (run >= 4) hits++;
            prev = b;
        end
        return hits;
    endfunction

    function automatic int exp_pick(input logic [3:0] m, input int ptr);
        for (int k = 0; k < 4; k++)
            if (m[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic add_total(input int h);
        exp_total = (exp_total + h > 65535) ? 65535 : exp_total + h;
    endtask

    // One transaction from idle: present mask for one edge, then wait (bounded) for done.
    task automatic run_txn(input logic [3:0] m, output logic [3:0] g, output logic [3:0] d,
                           output logic [2:0] hc, output logic ah, output int lat);
        req = m;
        @(posedge clk); #1;
        g = gnt; req = 4'b0; lat = 0;
        while (done === 4'b0 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        d = done; hc = hit_cnt; ah = any_hit;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 4'b0; data = 32'b0;
        repeat (2) @(posedge clk); #1;
        total++;
        if (gnt !== 4'b0 || done !== 4'b0 || hit_cnt !== 3'b0 || any_hit !== 1'b0 ||
            busy !== 1'b0 || hits_total !== 16'b0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b done=%b hit_cnt=%0d any_hit=%b busy=%b total=%0d, want all 0",
                     gnt, done, hit_cnt, any_hit, busy, hits_total);
        end
        reset = 1'b1;
        exp_total = 0; exp_ptr = 0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_req: busy=%b want 0", busy); end
    endtask

    task automatic test_single();
        data[7:0] = 8'h0F; req = 4'b0001;
        @(posedge clk); #1;
        total++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            bad++; $display("FAIL gnt_0f: gnt=%b busy=%b want 0001/1", gnt, busy);
        end
        req = 4'b0;
        repeat (7) @(posedge clk); #1;
        total++;
        if (done !== 4'b0 || gnt !== 4'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL last_shift_0f: done=%b gnt=%b busy=%b want 0000/0000/1", done, gnt, busy);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 4'b0001 || hit_cnt !== 3'd2 || any_hit !== 1'b1) begin
            bad++; $display("FAIL done_0f: done=%b hit_cnt=%0d any_hit=%b want 0001/2/1", done, hit_cnt, any_hit);
        end
        total++;
        if (hits_total !== 16'd0) begin bad++; $display("FAIL total_lag_0f: got %0d want 0", hits_total); end
        @(posedge clk); #1;
        add_total(2); exp_ptr = 1;
        total++;
        if (done !== 4'b0 || busy !== 1'b0 || hits_total !== 16'(exp_total) || hit_cnt !== 3'd2) begin
            bad++; $display("FAIL after_done_0f: done=%b busy=%b total=%0d hit_cnt=%0d want 0000/0/%0d/2",
                            done, busy, hits_total, hit_cnt, exp_total);
        end
    endtask

    task automatic test_counts();
        logic [7:0] words [3] = '{8'h00, 8'h55, 8'h87};
        int who  [3] = '{1, 2, 3};
        int want [3] = '{5, 0, 1};
        logic [3:0] g, d; logic [2:0] hc; logic ah; int lat;
        for (int k = 0; k < 3; k++) begin
            data[who[k]*8 +: 8] = words[k];
            run_txn(4'(1 << who[k]), g, d, hc, ah, lat);
            add_total(want[k]); exp_ptr = (who[k] + 1) % 4;
            total++;
            if (g !== 4'(1 << who[k]) || d !== 4'(1 << who[k])) begin
                bad++; $display("FAIL owner_%0d: gnt=%b done=%b want one-hot %0d", k, g, d, who[k]);
            end
            total++;
            if (hc !== 3'(want[k]) || ah !== (want[k] != 0)) begin
                bad++; $display("FAIL count_%h: hit_cnt=%0d any_hit=%b want %0d/%0d", words[k], hc, ah, want[k], want[k] != 0);
            end
            total++;
            if (lat != 8) begin bad++; $display("FAIL latency_%0d: got %0d want 8", k, lat); end
            total++;
            if (hits_total !== 16'(exp_total)) begin
                bad++; $display("FAIL total_%0d: got %0d want %0d", k, hits_total, exp_total);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [4];
        int seq [5];
        int gcyc [5];
        int ptr, cyc, ng, nd, idle_cnt, sum, h;
        ptr = exp_ptr;
        for (int k = 0; k < 5; k++) begin seq[k] = exp_pick(4'hF, ptr); ptr = (seq[k] + 1) % 4; end
        for (int k = 0; k < 4; k++) begin w[k] = 8'($urandom); data[k*8 +: 8] = w[k]; end
        cyc = 0; ng = 0; nd = 0; idle_cnt = 0; sum = 0;
        req = 4'hF;
        while (nd < 5 && cyc < 120) begin
            @(posedge clk); #1; cyc++;
            if (gnt !== 4'b0) begin
                total++;
                if (ng >= 5 || gnt !== 4'(1 << seq[ng])) begin
                    bad++; $display("FAIL rr_grant_%0d: gnt=%b want one-hot %0d", ng, gnt, (ng < 5) ? seq[ng] : -1);
                end
                if (ng < 5) gcyc[ng] = cyc;
                ng++;
                if (ng == 5) req = 4'b0;
            end
            if (ng >= 1 && ng < 5 && busy === 1'b0) idle_cnt++;
            if (done !== 4'b0) begin
                h = (nd < 5) ? ref_hits(16'(w[seq[nd]]), 8) : 0;
                total++;
                if (nd >= 5 || done !== 4'(1 << seq[nd]) || hit_cnt !== 3'(h)) begin
                    bad++; $display("FAIL rr_done_%0d: done=%b hit_cnt=%0d want one-hot %0d/%0d", nd, done, hit_cnt,
                                    (nd < 5) ? seq[nd] : -1, h);
                end
                sum += h; nd++;
            end
        end
        total++;
        if (nd < 5) begin bad++; $display("FAIL rr_timeout: dones=%0d want 5", nd); end
        for (int k = 1; k < 5; k++) begin
            total++;
            if (k < ng && gcyc[k] - gcyc[k-1] != 10) begin
                bad++; $display("FAIL rr_spacing_%0d: got %0d want 10", k, gcyc[k] - gcyc[k-1]);
            end
        end
        total++;
        if (idle_cnt != 4) begin bad++; $display("FAIL rr_idle_gaps: got %0d idle cycles want 4", idle_cnt); end
        @(posedge clk); #1;
        add_total(sum); exp_ptr = ptr;
        total++;
        if (hits_total !== 16'(exp_total)) begin
            bad++; $display("FAIL rr_total: got %0d want %0d", hits_total, exp_total);
        end
    endtask

    task automatic test_isolation();
        logic [3:0] g, d; logic [2:0] hc; logic ah; int lat;
        data[15:8] = 8'h07;
        run_txn(4'b0010, g, d, hc, ah, lat);
        add_total(2); exp_ptr = 2;
        total++;
        if (d !== 4'b0010 || hc !== 3'd2) begin
            bad++; $display("FAIL iso_first: done=%b hit_cnt=%0d want 0010/2", d, hc);
        end
        data[23:16] = 8'hF0;
        run_txn(4'b0100, g, d, hc, ah, lat);
        add_total(2); exp_ptr = 3;
        total++;
        if (d !== 4'b0100 || hc !== 3'd2) begin
            bad++; $display("FAIL iso_second: done=%b hit_cnt=%0d want 0100/2", d, hc);
        end
        total++;
        if (hits_total !== 16'(exp_total)) begin
            bad++; $display("FAIL iso_total: got %0d want %0d", hits_total, exp_total);
        end
    endtask

    task automatic test_midreset();
        logic [3:0] g, d; logic [2:0] hc; logic ah; int lat, own, h;
        logic seen;
        data[7:0] = 8'h00; req = 4'b0001;
        @(posedge clk); #1;
        req = 4'b0;
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_gnt: gnt=%b want 0001", gnt); end
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0 || done !== 4'b0 || hit_cnt !== 3'b0 || any_hit !== 1'b0 ||
            busy !== 1'b0 || hits_total !== 16'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: gnt=%b done=%b hit_cnt=%0d any_hit=%b busy=%b total=%0d, want all 0",
                     gnt, done, hit_cnt, any_hit, busy, hits_total);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_total = 0; exp_ptr = 0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done !== 4'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL mid_no_done: activity seen=%b want 0", seen); end
        data[23:16] = 8'($urandom); data[31:24] = 8'($urandom);
        own = exp_pick(4'b1100, exp_ptr);
        h   = ref_hits(16'(data[own*8 +: 8]), 8);
        run_txn(4'b1100, g, d, hc, ah, lat);
        add_total(h); exp_ptr = (own + 1) % 4;
        total++;
        if (g !== 4'(1 << own) || hc !== 3'(h)) begin
            bad++; $display("FAIL post_reset_pick: gnt=%b hit_cnt=%0d want one-hot %0d/%0d", g, hc, own, h);
        end
        total++;
        if (hits_total !== 16'(exp_total)) begin
            bad++; $display("FAIL post_reset_total: got %0d want %0d", hits_total, exp_total);
        end
    endtask

    task automatic test_random();
        logic [3:0] g, d, m; logic [2:0] hc; logic ah; int lat, own, h;
        for (int n = 0; n < 24; n++) begin
            m    = 4'($urandom_range(1, 15));
            data = $urandom;
            own  = exp_pick(m, exp_ptr);
            h    = ref_hits(16'(data[own*8 +: 8]), 8);
            run_txn(m, g, d, hc, ah, lat);
            add_total(h); exp_ptr = (own + 1) % 4;
            total++;
            if (g !== 4'(1 << own) || d !== 4'(1 << own)) begin
                bad++; $display("FAIL rand_owner_%0d: req=%b gnt=%b done=%b want one-hot %0d", n, m, g, d, own);
            end
            total++;
            if (hc !== 3'(h) || ah !== (h != 0)) begin
                bad++; $display("FAIL rand_count_%0d: word=%h hit_cnt=%0d any_hit=%b want %0d", n,
                                data[own*8 +: 8], hc, ah, h);
            end
            total++;
            if (hits_total !== 16'(exp_total)) begin
                bad++; $display("FAIL rand_total_%0d: got %0d want %0d", n, hits_total, exp_total);
            end
        end
    endtask

    // 16-bit all-zero words give 13 hits each, so 5042 words cross 0xFFFF.
    task automatic test_saturation();
        int words, exp2, waitc;
        words = 0; exp2 = 0;
        reset2 = 1'b0; req2 = 2'b0; data2 = 32'b0;
        repeat (2) @(posedge clk); #1;
        reset2 = 1'b1; req2 = 2'b11;
        while (words < 5044) begin
            waitc = 0;
            while (done2 === 2'b0 && waitc < 40) begin @(posedge clk); #1; waitc++; end
            if (done2 === 2'b0) begin
                total++; bad++;
                $display("FAIL sat_timeout: no done after %0d words", words);
                break;
            end
            if (words == 0) begin
                total++;
                if (hit_cnt2 !== 4'd13) begin bad++; $display("FAIL sat_word_hits: got %0d want 13", hit_cnt2); end
            end
            words++;
            exp2 = (exp2 + 13 > 65535) ? 65535 : exp2 + 13;
            @(posedge clk); #1;
            if (words == 1 || words == 5041 || words == 5042 || words == 5044) begin
                total++;
                if (hits_total2 !== 16'(exp2)) begin
                    bad++; $display("FAIL sat_total_%0d: got %0d want %0d", words, hits_total2, exp2);
                end
            end
        end
        req2 = 2'b0;
    endtask

    initial begin
        fork
            test_saturation();
            begin
                test_reset();
                test_single();
                test_counts();
                test_back_to_back();
                test_isolation();
                test_midreset();
                test_random();
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
